// File: rtl/spi_pwm_csr.sv
// SPI byte-stream register file driving N_CH PWM channels.
// Each channel's duty and period changes are shadowed until the counter wraps.
module spi_pwm_csr #(
  parameter int unsigned N_CH      = 7,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned PRESC_DIV = 1
) (
  input  logic            sys_clk,
  input  logic            rst,
  input  logic [7:0]      data_in,
  input  logic            data_rdy,
  input  logic            cs_active,
  output logic [7:0]      data_out,
  output logic            data_latch,
  output logic            err,
  output logic [N_CH-1:0] chip_out
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned BW = $clog2(NB + 1);
  localparam int unsigned PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

  typedef enum logic [2:0] {StIdle, StWr, StRd, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              latch_q, latch_d;
  logic              err_q, err_d;
  logic [4:0]        ch_q, ch_d;
  logic [1:0]        reg_q, reg_d;

  logic              strobe, hdr_bad, wr_fire, tick;
  logic [4:0]        hdr_ch;
  logic [1:0]        hdr_reg;
  logic [DATA_W-1:0] wr_val, rd_val;
  logic [PW-1:0]     presc_q;

  logic [DATA_W-1:0] duty_q      [N_CH];
  logic [DATA_W-1:0] period_q    [N_CH];
  logic [DATA_W-1:0] duty_sh_q   [N_CH];
  logic [DATA_W-1:0] period_sh_q [N_CH];
  logic [DATA_W-1:0] cnt_q       [N_CH];
  logic [N_CH-1:0]   en_q, inv_q;

  // A strobe while cs_active is low belongs to no frame and is dropped.
  assign strobe  = data_rdy & cs_active;
  assign hdr_ch  = data_in[6:2];
  assign hdr_reg = data_in[1:0];
  assign hdr_bad = (32'(hdr_ch) >= N_CH) || (hdr_reg == 2'd3);
  assign wr_val  = (shift_q << 8) | DATA_W'(data_in);

  // Reads see the pending (last written) values, not the shadows.
  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (32'(hdr_ch) == i) begin
        case (hdr_reg)
          2'd0:    rd_val = duty_q[i];
          2'd1:    rd_val = period_q[i];
          2'd2:    rd_val = DATA_W'({inv_q[i], en_q[i]});
          default: rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!cs_active) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (data_rdy) state_d = hdr_bad ? StErr : (data_in[7] ? StWr : StRd);
        StWr:   if (data_rdy && byte_cnt_q == BW'(NB - 1)) state_d = StDone;
        StRd: begin
          if (byte_cnt_q == BW'(NB) || (data_rdy && byte_cnt_q == BW'(NB - 1))) begin
            state_d = StDone;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    rd_buf_d   = rd_buf_q;
    data_out_d = data_out_q;
    latch_d    = 1'b0;
    err_d      = err_q;
    ch_d       = ch_q;
    reg_d      = reg_q;
    wr_fire    = 1'b0;
    if (strobe) begin
      unique case (state_q)
        StIdle: begin
          byte_cnt_d = '0;
          ch_d       = hdr_ch;
          reg_d      = hdr_reg;
          err_d      = hdr_bad;
          if (!hdr_bad && !data_in[7]) begin
            data_out_d = rd_val[DATA_W-1 -: 8];
            rd_buf_d   = rd_val << 8;
            latch_d    = 1'b1;
            byte_cnt_d = BW'(1);
          end
        end
        StWr: begin
          shift_d    = wr_val;
          byte_cnt_d = byte_cnt_q + BW'(1);
          wr_fire    = (byte_cnt_q == BW'(NB - 1));
        end
        StRd: begin
          if (byte_cnt_q < BW'(NB)) begin
            data_out_d = rd_buf_q[DATA_W-1 -: 8];
            rd_buf_d   = rd_buf_q << 8;
            latch_d    = 1'b1;
            byte_cnt_d = byte_cnt_q + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
      rd_buf_q   <= '0;
      data_out_q <= '0;
      latch_q    <= 1'b0;
      err_q      <= 1'b0;
      ch_q       <= '0;
      reg_q      <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      rd_buf_q   <= rd_buf_d;
      data_out_q <= data_out_d;
      latch_q    <= latch_d;
      err_q      <= err_d;
      ch_q       <= ch_d;
      reg_q      <= reg_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (rst) begin
        duty_q[i]   <= '0;
        period_q[i] <= '1;
        en_q[i]     <= 1'b0;
        inv_q[i]    <= 1'b0;
      end else if (wr_fire && 32'(ch_q) == i) begin
        case (reg_q)
          2'd0: duty_q[i]   <= wr_val;
          2'd1: period_q[i] <= wr_val;
          2'd2: begin
            en_q[i]  <= wr_val[0];
            inv_q[i] <= wr_val[1];
          end
          default: ;
        endcase
      end
    end
  end

  assign tick = (presc_q == PW'(PRESC_DIV - 1));

  always_ff @(posedge sys_clk) begin
    if (rst)       presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + PW'(1);
  end

  always_ff @(posedge sys_clk) begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (rst) begin
        cnt_q[i]       <= '0;
        duty_sh_q[i]   <= '0;
        period_sh_q[i] <= '1;
      end else if (!en_q[i]) begin
        cnt_q[i]       <= '0;
        duty_sh_q[i]   <= duty_q[i];
        period_sh_q[i] <= period_q[i];
      end else if (tick) begin
        if (cnt_q[i] == period_sh_q[i]) begin
          cnt_q[i]       <= '0;
          duty_sh_q[i]   <= duty_q[i];
          period_sh_q[i] <= period_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + DATA_W'(1);
        end
      end
    end
  end

  always_comb begin
    chip_out = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      chip_out[i] = (en_q[i] & (cnt_q[i] < duty_sh_q[i])) ^ inv_q[i];
    end
  end

  assign data_out   = data_out_q;
  assign data_latch = latch_q;
  assign err        = err_q;

endmodule

// File: tb/tb_spi_pwm_csr.sv
// Randomised bench for spi_pwm_csr: frame-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_spi_pwm_csr;

  localparam int NCH = 7;
  localparam int DW  = 16;
  localparam int NB  = DW / 8;
  localparam int PD  = 1;
  localparam int unsigned MASK = 32'hFFFF_FFFF >> (32 - DW);

  logic           sys_clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     data_in = 8'h00;
  logic           data_rdy = 1'b0;
  logic           cs_active = 1'b0;
  logic [7:0]     data_out;
  logic           data_latch;
  logic           err;
  logic [NCH-1:0] chip_out;

  spi_pwm_csr #(
    .N_CH      (NCH),
    .DATA_W    (DW),
    .PRESC_DIV (PD)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_rdy   (data_rdy),
    .cs_active  (cs_active),
    .data_out   (data_out),
    .data_latch (data_latch),
    .err        (err),
    .chip_out   (chip_out)
  );

  initial forever #5 sys_clk = ~sys_clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents, frame progress and per-channel PWM position.
  int unsigned m_duty[NCH], m_per[NCH], m_cnt[NCH], m_dsh[NCH], m_psh[NCH];
  bit          m_en[NCH], m_inv[NCH];
  int          m_mode;  // 0 waiting for header, 1 writing, 2 reading, 3 ignoring
  int          m_reg, m_ch, m_cyc;
  byte unsigned m_wrq[$], m_rdq[$];
  bit          m_err, m_latch, model_ok;
  byte unsigned m_dout;

  function automatic int unsigned reg_value(input int ch, input int rg);
    if (rg == 0) return m_duty[ch];
    if (rg == 1) return m_per[ch];
    return (m_inv[ch] ? 2 : 0) + (m_en[ch] ? 1 : 0);
  endfunction

  function automatic logic [NCH-1:0] exp_chip();
    logic [NCH-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) v[c] = (m_en[c] && (m_cnt[c] < m_dsh[c])) ^ m_inv[c];
    return v;
  endfunction

  task automatic present();
    m_dout  = m_rdq.pop_front();
    m_latch = 1'b1;
  endtask

  task automatic model_step();
    int ch, rg;
    int unsigned v;
    bit tk;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_duty[c] = 0; m_per[c] = MASK; m_cnt[c] = 0; m_dsh[c] = 0; m_psh[c] = MASK;
        m_en[c] = 0; m_inv[c] = 0;
      end
      m_mode = 0; m_err = 0; m_latch = 0; m_dout = 0; m_cyc = 0;
      m_wrq.delete(); m_rdq.delete();
      model_ok = 1;
      return;
    end
    tk = (m_cyc % PD) == PD - 1;
    m_cyc++;
    m_latch = 0;
    for (int c = 0; c < NCH; c++) begin
      if (!m_en[c]) begin
        m_cnt[c] = 0; m_dsh[c] = m_duty[c]; m_psh[c] = m_per[c];
      end else if (tk) begin
        if (m_cnt[c] == m_psh[c]) begin
          m_cnt[c] = 0; m_dsh[c] = m_duty[c]; m_psh[c] = m_per[c];
        end else begin
          m_cnt[c]++;
        end
      end
    end
    if (!cs_active) begin
      m_mode = 0;
      m_wrq.delete();
    end else if (data_rdy) begin
      if (m_mode == 0) begin
        ch = int'(data_in[6:2]);
        rg = int'(data_in[1:0]);
        if (ch >= NCH || rg == 3) begin
          m_err = 1; m_mode = 3;
        end else begin
          m_err = 0; m_ch = ch; m_reg = rg;
          if (data_in[7]) begin
            m_mode = 1; m_wrq.delete();
          end else begin
            v = reg_value(ch, rg);
            m_rdq.delete();
            for (int k = NB - 1; k >= 0; k--) m_rdq.push_back(8'(v >> (8 * k)));
            present();
            m_mode = (m_rdq.size() == 0) ? 3 : 2;
          end
        end
      end else if (m_mode == 1) begin
        m_wrq.push_back(data_in);
        if (m_wrq.size() == NB) begin
          v = 0;
          foreach (m_wrq[k]) v = (v << 8) | m_wrq[k];
          v &= MASK;
          if (m_reg == 0) m_duty[m_ch] = v;
          else if (m_reg == 1) m_per[m_ch] = v;
          else begin m_en[m_ch] = v[0]; m_inv[m_ch] = v[1]; end
          m_mode = 3;
        end
      end else if (m_mode == 2) begin
        present();
        if (m_rdq.size() == 0) m_mode = 3;
      end
    end
  endtask

  initial forever begin
    @(posedge sys_clk);
    model_step();
  end

  byte unsigned rx_q[$];

  initial forever begin
    @(negedge sys_clk);
    if (model_ok) begin
      check("data_out", 32'(data_out), 32'(m_dout));
      check("data_latch", 32'(data_latch), 32'(m_latch));
      check("err", 32'(err), 32'(m_err));
      check("chip_out", 32'(chip_out), 32'(exp_chip()));
      if (data_latch) rx_q.push_back(data_out);
    end
  end

  byte unsigned tx_q[$];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic put(input logic [7:0] b);
    data_in  = b;
    data_rdy = 1'b1;
    step(1);
    data_rdy = 1'b0;
    data_in  = 8'($urandom);
  endtask

  task automatic send_frame(input int gap_max, input int rst_at, input bit drop_rdy);
    cs_active = 1'b1;
    step(1);
    foreach (tx_q[k]) begin
      if (k == rst_at) begin
        rst = 1'b1; step(1); rst = 1'b0;
      end
      put(tx_q[k]);
      if (gap_max > 0) step($urandom_range(gap_max, 0));
    end
    cs_active = 1'b0;
    if (drop_rdy) begin
      data_in = 8'($urandom); data_rdy = 1'b1;
    end
    step(1);
    data_rdy = 1'b0;
    step(1);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    tx_q.delete(); tx_q.push_back(a); tx_q.push_back(b); tx_q.push_back(c);
    send_frame(0, -1, 1'b0);
  endtask

  task automatic read_reg(input int ch, input int rg, input int extra, output int unsigned val);
    tx_q.delete();
    tx_q.push_back({1'b0, 5'(ch), 2'(rg)});
    for (int k = 0; k < NB + extra; k++) tx_q.push_back(8'h00);
    rx_q.delete();
    send_frame(0, -1, 1'b0);
    val = 0;
    foreach (rx_q[k]) val = (val << 8) | rx_q[k];
  endtask

  task automatic cnt_high(input int c, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge sys_clk);
      if (chip_out[c]) hi++;
    end
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int unsigned v;
    int hi;
    repeat (3) @(posedge sys_clk);
    #1;
    rst = 1'b0;
    @(negedge sys_clk);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_latch", 32'(data_latch), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_chip_out", 32'(chip_out), 32'h0);
    @(posedge sys_clk);
    #1;

    // ch2: duty 64, period 127, enabled -> 64 high / 64 low
    send3(8'h88, 8'h00, 8'h40);
    send3(8'h89, 8'h00, 8'h7F);
    send3(8'h8A, 8'h00, 8'h01);
    step(10);
    cnt_high(2, 256, hi);
    check("ch2_high_count_64", 32'(hi), 32'd128);
    check("other_ch_low", 32'(chip_out & ~7'h04), 32'h0);

    read_reg(2, 0, 1, v);
    check("read_latch_count", 32'(rx_q.size()), 32'd2);
    check("read_duty", v, 32'h0040);

    rx_q.delete();
    send3(8'h9C, 8'h12, 8'h34);
    check("bad_hdr_err", 32'(err), 32'h1);
    check("bad_hdr_no_latch", 32'(rx_q.size()), 32'd0);
    read_reg(2, 0, 0, v);
    check("err_cleared", 32'(err), 32'h0);
    check("bad_hdr_duty_kept", v, 32'h0040);
    read_reg(2, 1, 0, v);
    check("read_period", v, 32'h007F);

    cs_active = 1'b1;
    step(1);
    put(8'h88);
    put(8'h12);
    cs_active = 1'b0;
    step(2);
    read_reg(2, 0, 0, v);
    check("abort_duty_kept", v, 32'h0040);

    send3(8'h88, 8'h00, 8'h10);
    step(300);
    cnt_high(2, 256, hi);
    check("ch2_high_count_16", 32'(hi), 32'd32);
    send3(8'h8A, 8'h00, 8'h03);
    step(40);
    send3(8'h8A, 8'h00, 8'h02);
    step(3);
    check("disabled_inverted", 32'(chip_out[2]), 32'h1);

    cs_active = 1'b1;
    step(1);
    put(8'h89);
    put(8'h00);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    cs_active = 1'b0;
    @(negedge sys_clk);
    check("midrst_chip_out", 32'(chip_out), 32'h0);
    check("midrst_err", 32'(err), 32'h0);
    check("midrst_data_out", 32'(data_out), 32'h0);
    @(posedge sys_clk);
    #1;
    read_reg(2, 1, 0, v);
    check("midrst_period", v, MASK);

    for (int it = 0; it < 500; it++) begin
      int rg, nbytes, rst_at;
      logic [7:0] hdr;
      int unsigned val;
      rg  = $urandom_range(3, 0);
      hdr = {1'($urandom_range(1, 0)), 5'($urandom_range(NCH, 0)), 2'(rg)};
      if ($urandom_range(15, 0) == 0) hdr = 8'($urandom);
      val = (rg == 1) ? $urandom_range(30, 0) : (rg == 0) ? $urandom_range(34, 0)
                                                         : $urandom_range(255, 0);
      nbytes = ($urandom_range(5, 0) == 0) ? $urandom_range(NB + 1, 0) : NB;
      tx_q.delete();
      tx_q.push_back(hdr);
      for (int k = 0; k < nbytes; k++) begin
        if (k < NB) tx_q.push_back(8'(val >> (8 * (NB - 1 - k))));
        else        tx_q.push_back(8'($urandom));
      end
      rst_at = ($urandom_range(60, 0) == 0) ? $urandom_range(nbytes, 0) : -1;
      send_frame(3, rst_at, $urandom_range(15, 0) == 0);
      step($urandom_range(6, 0));
    end

    step(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
